// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between the icache and the
// dcache. The grant is combinational and the dcache has priority. A 16-entry
// ownership table records which client owns each outstanding load tag, and
// returned data is routed to that client.
//
// Optional build macro MEM_ARB_FAIRNESS_EN: adds a starvation counter. After
// STARVE_LIMIT consecutive icache losses, the icache wins the next contested
// cycle.
//
// Handshake: a client request is accepted in the cycle that the client wins
// the grant and the memory returns a nonzero transaction tag. A zero tag is a
// rejection, and the client presents the request again. The memory returns
// data with a nonzero data_tag for exactly one cycle and does not wait for the
// client.
//
// While reset is high, every output is held at 0 (command BUS_NONE).
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Icache_command,
    input  logic [31:0] Icache_addr,
    input  logic [1:0]  Dcache_command,
    input  logic [31:0] Dcache_addr,
    input  logic [63:0] Dcache_data,
    input  logic [3:0]  mem2arb_transaction_tag,
    input  logic [63:0] mem2arb_data,
    input  logic [3:0]  mem2arb_data_tag,
    output logic [1:0]  arb2mem_command,
    output logic [31:0] arb2mem_addr,
    output logic [63:0] arb2mem_data,
    output logic [3:0]  Icache_transaction_tag,
    output logic [3:0]  Dcache_transaction_tag,
    output logic [63:0] Icache_data,
    output logic [63:0] Dcache_data_out,
    output logic [3:0]  Icache_data_tag,
    output logic [3:0]  Dcache_data_tag,
    output logic        stray_return
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    logic        icache_req;
    logic        dcache_req;
    logic        force_icache;
    logic        grant_icache;
    logic        grant_dcache;
    logic        accept_load;
    logic        ret_hit;
    logic        ret_stray;
    logic [15:0] tag_valid;
    logic [15:0] tag_owner;
    logic        stray_q;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Count consecutive icache losses, saturating. A win or an idle icache clears the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (icache_req && !grant_icache) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign force_icache = (starve_cnt == CNT_MAX);
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign force_icache = 1'b0;
`endif

    // Grant, forwarding, acceptance tags and return routing. All of it is
    // combinational, and all outputs are gated to 0 while reset is high.
    always_comb begin
        arb2mem_command        = BUS_NONE;
        arb2mem_addr           = '0;
        arb2mem_data           = '0;
        Icache_transaction_tag = '0;
        Dcache_transaction_tag = '0;
        Icache_data            = '0;
        Dcache_data_out        = '0;
        Icache_data_tag        = '0;
        Dcache_data_tag        = '0;

        icache_req   = (Icache_command != BUS_NONE);
        dcache_req   = (Dcache_command != BUS_NONE);
        grant_icache = icache_req && (!dcache_req || force_icache);
        grant_dcache = dcache_req && !grant_icache;

        accept_load = !reset && (mem2arb_transaction_tag != 4'd0) &&
                      ((grant_icache && (Icache_command == BUS_LOAD)) ||
                       (grant_dcache && (Dcache_command == BUS_LOAD)));
        ret_hit   = !reset && (mem2arb_data_tag != 4'd0) &&  tag_valid[mem2arb_data_tag];
        ret_stray = !reset && (mem2arb_data_tag != 4'd0) && !tag_valid[mem2arb_data_tag];

        if (!reset) begin
            if (grant_icache) begin
                arb2mem_command        = Icache_command;
                arb2mem_addr           = Icache_addr;
                Icache_transaction_tag = mem2arb_transaction_tag;
            end else if (grant_dcache) begin
                arb2mem_command        = Dcache_command;
                arb2mem_addr           = Dcache_addr;
                arb2mem_data           = Dcache_data;
                Dcache_transaction_tag = mem2arb_transaction_tag;
            end

            if (ret_hit) begin
                if (tag_owner[mem2arb_data_tag]) begin
                    Dcache_data_tag = mem2arb_data_tag;
                    Dcache_data_out = mem2arb_data;
                end else begin
                    Icache_data_tag = mem2arb_data_tag;
                    Icache_data     = mem2arb_data;
                end
            end
        end
    end

    // Ownership table. A return clears its entry, and a new acceptance of the
    // same tag in the same cycle overrides that clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
            tag_owner <= '0;
            stray_q   <= 1'b0;
        end else begin
            if (ret_hit) begin
                tag_valid[mem2arb_data_tag] <= 1'b0;
            end
            if (accept_load) begin
                tag_valid[mem2arb_transaction_tag] <= 1'b1;
                tag_owner[mem2arb_transaction_tag] <= grant_dcache;
            end
            if (ret_stray) begin
                stray_q <= 1'b1;
            end
        end
    end

    assign stray_return = stray_q && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed stimulus for mem_port_arbiter.
// A reference model keeps tag ownership in an associative array. For every
// driven cycle it pushes the expected response into exp_q. A separate monitor
// pops each expected response on the falling edge and compares it field by
// field with the DUT outputs.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clock;
    logic        reset;
    logic [1:0]  Icache_command;
    logic [31:0] Icache_addr;
    logic [1:0]  Dcache_command;
    logic [31:0] Dcache_addr;
    logic [63:0] Dcache_data;
    logic [3:0]  mem2arb_transaction_tag;
    logic [63:0] mem2arb_data;
    logic [3:0]  mem2arb_data_tag;
    logic [1:0]  arb2mem_command;
    logic [31:0] arb2mem_addr;
    logic [63:0] arb2mem_data;
    logic [3:0]  Icache_transaction_tag;
    logic [3:0]  Dcache_transaction_tag;
    logic [63:0] Icache_data;
    logic [63:0] Dcache_data_out;
    logic [3:0]  Icache_data_tag;
    logic [3:0]  Dcache_data_tag;
    logic        stray_return;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .Icache_command         (Icache_command),
        .Icache_addr            (Icache_addr),
        .Dcache_command         (Dcache_command),
        .Dcache_addr            (Dcache_addr),
        .Dcache_data            (Dcache_data),
        .mem2arb_transaction_tag(mem2arb_transaction_tag),
        .mem2arb_data           (mem2arb_data),
        .mem2arb_data_tag       (mem2arb_data_tag),
        .arb2mem_command        (arb2mem_command),
        .arb2mem_addr           (arb2mem_addr),
        .arb2mem_data           (arb2mem_data),
        .Icache_transaction_tag (Icache_transaction_tag),
        .Dcache_transaction_tag (Dcache_transaction_tag),
        .Icache_data            (Icache_data),
        .Dcache_data_out        (Dcache_data_out),
        .Icache_data_tag        (Icache_data_tag),
        .Dcache_data_tag        (Dcache_data_tag),
        .stray_return           (stray_return)
    );

    // Clock and reset: 10-time-unit period, with reset held from time 0.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  itag;
        logic [3:0]  dtag;
        logic [3:0]  irtag;
        logic [63:0] irdata;
        logic [3:0]  drtag;
        logic [63:0] drdata;
        logic        stray;
    } resp_t;

    localparam int W = $bits(resp_t);

    logic [W-1:0] exp_q[$];

    // Reference model state.
    int owner_of[int];   // outstanding tag -> 0 for icache, 1 for dcache
    int losses;          // consecutive icache losses
    bit stray_m;         // sticky flag for returns of unowned tags

    int passed;
    int total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Driver: applies one cycle of inputs just after the rising edge, pushes
    // the expected response, then advances the model to the next edge.
    task automatic drive(input logic rst, input logic [1:0] icmd, input logic [31:0] iaddr,
                         input logic [1:0] dcmd, input logic [31:0] daddr, input logic [63:0] ddata,
                         input logic [3:0] mtag, input logic [63:0] rdata, input logic [3:0] rtag);
        resp_t e;
        bit    i_wants, d_wants, i_wins, d_wins, stray_now;
        @(posedge clock);
        #1;
        reset                   = rst;
        Icache_command          = icmd;
        Icache_addr             = iaddr;
        Dcache_command          = dcmd;
        Dcache_addr             = daddr;
        Dcache_data             = ddata;
        mem2arb_transaction_tag = mtag;
        mem2arb_data            = rdata;
        mem2arb_data_tag        = rtag;
        e = '0;
        if (rst) begin
            exp_q.push_back(e);
            owner_of.delete();
            losses  = 0;
            stray_m = 0;
            return;
        end
        i_wants = (icmd != 2'd0);
        d_wants = (dcmd != 2'd0);
`ifdef MEM_ARB_FAIRNESS_EN
        i_wins = i_wants && (!d_wants || losses >= STARVE_LIMIT);
`else
        i_wins = i_wants && !d_wants;
`endif
        d_wins = d_wants && !i_wins;
        if (i_wins) begin
            e.cmd  = icmd;
            e.addr = iaddr;
            e.itag = mtag;
        end else if (d_wins) begin
            e.cmd  = dcmd;
            e.addr = daddr;
            e.data = ddata;
            e.dtag = mtag;
        end
        stray_now = 0;
        if (rtag != 4'd0) begin
            if (owner_of.exists(int'(rtag))) begin
                if (owner_of[int'(rtag)] == 1) begin
                    e.drtag  = rtag;
                    e.drdata = rdata;
                end else begin
                    e.irtag  = rtag;
                    e.irdata = rdata;
                end
                owner_of.delete(int'(rtag));
            end else begin
                stray_now = 1;
            end
        end
        e.stray = stray_m;
        exp_q.push_back(e);
        if (stray_now) stray_m = 1;
        if (mtag != 4'd0) begin
            if (i_wins && icmd == 2'd1) owner_of[int'(mtag)] = 0;
            if (d_wins && dcmd == 2'd1) owner_of[int'(mtag)] = 1;
        end
        if (i_wants && !i_wins) losses = (losses < STARVE_LIMIT) ? losses + 1 : STARVE_LIMIT;
        else losses = 0;
    endtask

    // Scoreboard monitor: on the falling edge, compare the DUT outputs with the oldest expectation.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            resp_t e;
            e = exp_q.pop_front();
            check("arb2mem_command",        64'(arb2mem_command),        64'(e.cmd));
            check("arb2mem_addr",           64'(arb2mem_addr),           64'(e.addr));
            check("arb2mem_data",           arb2mem_data,                e.data);
            check("Icache_transaction_tag", 64'(Icache_transaction_tag), 64'(e.itag));
            check("Dcache_transaction_tag", 64'(Dcache_transaction_tag), 64'(e.dtag));
            check("Icache_data_tag",        64'(Icache_data_tag),        64'(e.irtag));
            check("Icache_data",            Icache_data,                 e.irdata);
            check("Dcache_data_tag",        64'(Dcache_data_tag),        64'(e.drtag));
            check("Dcache_data_out",        Dcache_data_out,             e.drdata);
            check("stray_return",           64'(stray_return),           64'(e.stray));
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic with occasional resets.
    initial begin
        logic [1:0] icmd, dcmd;
        logic [3:0] mtag, rtag;
        passed                  = 0;
        total                   = 0;
        losses                  = 0;
        stray_m                 = 0;
        reset                   = 1'b1;
        Icache_command          = '0;
        Icache_addr             = '0;
        Dcache_command          = '0;
        Dcache_addr             = '0;
        Dcache_data             = '0;
        mem2arb_transaction_tag = '0;
        mem2arb_data            = '0;
        mem2arb_data_tag        = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Icache load alone, then its return.
        drive(0, 1, 32'h100, 0, 0, 0, 4'd3, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'hDEAD, 4'd3);
        // Contested load: the dcache wins, and the return goes to the dcache.
        drive(0, 1, 32'h200, 1, 32'h300, 64'h1111, 4'd5, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'hBEEF, 4'd5);
        // Store with tag 7, then a return of tag 7 that nobody owns.
        drive(0, 0, 0, 2, 32'h400, 64'hCAFE_F00D, 4'd7, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'h7777, 4'd7);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Tag 2: icache owner, then a same-cycle return and dcache re-acceptance.
        drive(0, 1, 32'h500, 0, 0, 0, 4'd2, 0, 0);
        drive(0, 0, 0, 1, 32'h600, 0, 4'd2, 64'h2222, 4'd2);
        drive(0, 0, 0, 0, 0, 0, 0, 64'h3333, 4'd2);
        // Tag 9 outstanding across a one-cycle reset, then its return.
        drive(0, 1, 32'h900, 0, 0, 0, 4'd9, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 64'h9999, 4'd9);
        // Both caches request continuously.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 32'h1000 + 32'(i), 1, 32'h2000 + 32'(i), 64'(i), 4'(1 + i), 0, 0);
        end

        for (int i = 0; i < 600; i++) begin
            icmd = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'd0;
            dcmd = 2'($urandom_range(0, 2));
            mtag = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rtag = ($urandom_range(0, 4) < 2) ? 4'd0 : 4'($urandom_range(1, 15));
            drive(($urandom_range(0, 99) == 0), icmd, $urandom, dcmd, $urandom,
                  {$urandom, $urandom}, mtag, {$urandom, $urandom}, rtag);
        end

        repeat (3) @(posedge clock);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the non-blocking instruction cache and the data cache. It forwards one request per cycle, hands the memory's transaction tag back to the winning client, and records which client owns each outstanding load tag. Returned data is routed to that client. It sits directly between icache_nb (and the dcache) and the memory model.

## Interface
- STARVE_LIMIT, 4: consecutive icache losses after which the icache wins the next contested cycle (fairness build only).
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- Icache_command  in  MEM_COMMAND (2)  icache request: BUS_NONE or BUS_LOAD
- Icache_addr  in  ADDR (32)  icache block address
- Dcache_command  in  MEM_COMMAND (2)  dcache request: BUS_NONE, BUS_LOAD or BUS_STORE
- Dcache_addr  in  ADDR (32)  dcache address
- Dcache_data  in  MEM_BLOCK (64)  store data
- mem2arb_transaction_tag  in  MEM_TAG (4)  tag for the request this cycle; 0 means rejected
- mem2arb_data  in  MEM_BLOCK (64)  returned block
- mem2arb_data_tag  in  MEM_TAG (4)  tag of the returned block; 0 means none
- arb2mem_command  out  MEM_COMMAND (2)  forwarded command
- arb2mem_addr  out  ADDR (32)  forwarded address
- arb2mem_data  out  MEM_BLOCK (64)  forwarded store data
- Icache_transaction_tag / Dcache_transaction_tag  out  MEM_TAG (4)  per-client acceptance tag
- Icache_data / Dcache_data_out  out  MEM_BLOCK (64)  returned block
- Icache_data_tag / Dcache_data_tag  out  MEM_TAG (4)  returned tag routed to owner; 0 otherwise

## Operation
- Grant is combinational each cycle. Only one requester: it wins. Both requesting: the dcache wins, unless fairness forces the icache.
- arb2mem_command/addr/data come from the winner. With no requester, the command is BUS_NONE and addr/data are 0. arb2mem_data is 0 when the icache wins.
- The winner's transaction_tag equals mem2arb_transaction_tag. The loser's transaction_tag is 0. A rejected request (tag 0) is re-presented by the client; the arbiter keeps no record of it.
- Ownership table: valid bit and owner bit (0 = icache, 1 = dcache) for tags 1..15.
  - On an accepted BUS_LOAD with tag T (nonzero), set valid[T] and owner[T] at the clock edge.
  - Stores are not recorded.
- Return: when mem2arb_data_tag = T, T is nonzero and valid[T] is set, drive the owner's data_tag = T and the owner's data = mem2arb_data, combinationally. Clear valid[T] at the edge. The other client sees tag 0 and data 0.
- Return of an unowned tag: dropped, both clients see 0. Sticky debug flag `stray_return` (internal) is set.
- Same-cycle return of tag T and new acceptance of tag T: the return routes to the old owner, and the new ownership wins at the edge (set overrides clear).

## Timing
- Request path and return path both have zero latency, purely combinational. Table update takes 1 cycle.
- Reset values:
  - all outputs 0 (command BUS_NONE)
  - ownership table all invalid
  - starvation counter 0
- Reset mid-operation clears all ownership. Returns that arrive after reset for pre-reset tags are dropped as unowned.
- Starvation counter (fairness build):
  - Increments, saturating at STARVE_LIMIT, each cycle the icache requests and loses.
  - Resets to 0 when the icache wins or does not request.
  - When counter == STARVE_LIMIT and both request, the icache wins.
  - A rejected icache win still counts as a win.

## Configuration
- MEM_ARB_FAIRNESS_EN defined: the starvation counter and forced icache grant are as above.
- Undefined: strict dcache priority, no counter, and the STARVE_LIMIT parameter is unused.

## Test plan
- Icache BUS_LOAD at 0x100 alone, memory tag 3 → arb2mem_addr=0x100, Icache_transaction_tag=3. Later data_tag=3, data=0xDEAD → Icache_data_tag=3, Icache_data=0xDEAD, Dcache_data_tag=0.
- Both load in the same cycle, memory tag 5 → dcache granted, Dcache_transaction_tag=5, Icache_transaction_tag=0. Return of tag 5 goes to the dcache only.
- Fairness build, STARVE_LIMIT=4, both request continuously → dcache wins cycles 0–3, icache wins cycle 4, counter returns to 0. Non-fairness build: dcache wins all cycles.
- Dcache BUS_STORE accepted with tag 7, then data_tag=7 appears → both clients see data_tag 0 and stray_return is set.
- Same cycle: return tag 2 (owned by icache) and new dcache load accepted with tag 2 → Icache_data_tag=2 this cycle. The next return of tag 2 goes to the dcache.
- Icache load outstanding on tag 9, reset asserted for 1 cycle, then data_tag=9 → dropped, all outputs 0.
